// File: rtl/fifo_wr_arbiter.sv
// Write side of the async FIFO: round-robin arbitration of two requesters onto one write port,
// binary/Gray write pointer, registered full and sticky overflow; almost-full needs FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_arbiter #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                 wr_clk,
  input  logic                 wr_rstn,
  input  logic [1:0]           req_valid,
  input  logic [DATA_SIZE-1:0] req_data0,
  input  logic [DATA_SIZE-1:0] req_data1,
  output logic [1:0]           req_ready,
  input  logic [ADDR_SIZE:0]   wrq2_rptr,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic [ADDR_SIZE:0]   wr_ptr,
  output logic                 wr_full,
  output logic                 wr_almost_full,
  output logic                 wr_ovf
);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wr_ptr_q, wgray_d;
  logic [ADDR_SIZE:0] rptr_full;
  logic               wr_full_q, wr_full_d;
  logic               last_gnt_q, last_gnt_d;
  logic               wr_ovf_q, wr_ovf_d;
  logic [1:0]         gnt;

  // last_gnt_q names the requester that lost priority; the other one wins a tie.
  always_comb begin
    gnt = 2'b00;
    if (wr_rstn && !wr_full_q) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    wr_data = '0;
    if (gnt[0]) begin
      wr_data = req_data0;
    end else if (gnt[1]) begin
      wr_data = req_data1;
    end
  end

  assign req_ready  = gnt;
  assign wr_en      = |(req_valid & gnt);
  assign wr_addr    = wbin_q[ADDR_SIZE-1:0];
  assign wr_ptr     = wr_ptr_q;
  assign wr_full    = wr_full_q;
  assign wr_ovf     = wr_ovf_q;

  assign wbin_d     = wbin_q + {{ADDR_SIZE{1'b0}}, wr_en};
  assign wgray_d    = wbin_d ^ (wbin_d >> 1);
  // Full when the next write pointer is exactly one lap ahead of the read pointer.
  assign rptr_full  = {~wrq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wrq2_rptr[ADDR_SIZE-2:0]};
  assign wr_full_d  = (wgray_d == rptr_full);
  assign wr_ovf_d   = wr_ovf_q | ((|req_valid) & wr_full_q);
  assign last_gnt_d = wr_en ? gnt[1] : last_gnt_q;

  always_ff @(posedge wr_clk) begin
    if (!wr_rstn) begin
      wbin_q     <= '0;
      wr_ptr_q   <= '0;
      wr_full_q  <= 1'b0;
      last_gnt_q <= 1'b1;
      wr_ovf_q   <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wr_ptr_q   <= wgray_d;
      wr_full_q  <= wr_full_d;
      last_gnt_q <= last_gnt_d;
      wr_ovf_q   <= wr_ovf_d;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [ADDR_SIZE+1:0] DEPTH  = (ADDR_SIZE+2)'(1 << ADDR_SIZE);
  localparam logic [ADDR_SIZE+1:0] AF_LIM = (ADDR_SIZE+2)'(AF_MARGIN);

  logic [ADDR_SIZE:0]   rbin;
  logic [ADDR_SIZE:0]   used;
  logic [ADDR_SIZE+1:0] free_slots;
  logic                 wr_af_q, wr_af_d;

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      rbin[i] = ^(wrq2_rptr >> i);
    end
    used       = wbin_d - rbin;
    free_slots = DEPTH - {1'b0, used};
    wr_af_d    = (free_slots <= AF_LIM);
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rstn) begin
      wr_af_q <= 1'b0;
    end else begin
      wr_af_q <= wr_af_d;
    end
  end

  assign wr_almost_full = wr_af_q;
`else
  assign wr_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: reference model plus write scoreboard, one task per scenario.
module tb_fifo_wr_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    valid;
  logic [DW-1:0] d0, d1;
  logic [1:0]    ready;
  logic [AW:0]   rptr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   wr_ptr;
  logic          wr_full, wr_af, wr_ovf;

  int checks = 0;
  int failures = 0;

  logic [AW+DW-1:0] sb[$];
  logic [AW+DW-1:0] got, exp_w;

  logic [AW:0] m_wbin;
  logic        m_full, m_last, m_ovf, m_af;
  logic [1:0]  m_gnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .AF_MARGIN(2)) dut (
    .wr_clk(clk), .wr_rstn(rstn), .req_valid(valid), .req_data0(d0), .req_data1(d1),
    .req_ready(ready), .wrq2_rptr(rptr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ptr(wr_ptr), .wr_full(wr_full),
    .wr_almost_full(wr_af), .wr_ovf(wr_ovf)
  );

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] from_gray(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle of stimulus just after a rising edge, queue the expected write, stop at the falling edge.
  task automatic apply(input logic rst_n, input logic [1:0] v, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW:0] rp);
    rstn  = rst_n;
    valid = v;
    d0    = a;
    d1    = b;
    rptr  = rp;
    m_gnt = 2'b00;
    if (rst_n && !m_full) begin
      if (v == 2'b11) m_gnt = m_last ? 2'b01 : 2'b10;
      else            m_gnt = v;
    end
    if (m_gnt[0])      sb.push_back({m_wbin[AW-1:0], a});
    else if (m_gnt[1]) sb.push_back({m_wbin[AW-1:0], b});
    @(negedge clk);
  endtask

  // Cross the rising edge and move the reference model forward.
  task automatic advance();
    logic [AW:0] nb, used;
    @(posedge clk);
    if (!rstn) begin
      m_wbin = '0; m_full = 1'b0; m_last = 1'b1; m_ovf = 1'b0; m_af = 1'b0;
    end else begin
      nb    = m_wbin + {{AW{1'b0}}, |m_gnt};
      used  = nb - from_gray(rptr);
      m_ovf = m_ovf | ((|valid) & m_full);
      if (|m_gnt) m_last = m_gnt[1];
      m_full = (used == 5'd16);
`ifdef FIFO_WR_ALMOST_FULL_EN
      m_af = (used >= 5'd14);
`endif
      m_wbin = nb;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 2'b11, 8'h11, 8'h22, '0);
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", ready); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
      advance();
    end
    sb.delete();
    apply(1'b1, 2'b00, '0, '0, '0);
    checks++; if (wr_ptr !== 5'b00000) begin failures++; $display("FAIL reset_wr_ptr got=%b want=00000", wr_ptr); end
    checks++; if (wr_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", wr_full); end
    checks++; if (wr_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", wr_ovf); end
    checks++; if (wr_af !== 1'b0) begin failures++; $display("FAIL reset_af got=%b want=0", wr_af); end
    advance();
  endtask

  task automatic test_contention();
    logic [DW-1:0] a, b, exp_d;
    logic [1:0]    exp_r;
    test_reset();
    for (int i = 0; i < 6; i++) begin
      a = 8'hA0 + 8'(i);
      b = 8'hB0 + 8'(i);
      apply(1'b1, 2'b11, a, b, '0);
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? a : b;
      checks++; if (ready !== exp_r) begin failures++; $display("FAIL contention_ready cyc=%0d got=%b want=%b", i, ready, exp_r); end
      checks++; if (wr_data !== exp_d) begin failures++; $display("FAIL contention_data cyc=%0d got=%h want=%h", i, wr_data, exp_d); end
      checks++;
      if (wr_en !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL contention_write cyc=%0d wr_en=%b queued=%0d", i, wr_en, sb.size());
      end else begin
        got = {wr_addr, wr_data}; exp_w = sb.pop_front();
        if (got !== exp_w) begin failures++; $display("FAIL contention_sb cyc=%0d got=%h want=%h", i, got, exp_w); end
      end
      advance();
    end
  endtask

  task automatic test_fill_and_ovf();
    logic [DW-1:0] a;
    logic          exp_af;
    test_reset();
    for (int i = 0; i < 16; i++) begin
      a = 8'h40 + 8'(i);
      apply(1'b1, 2'b01, a, 8'hEE, '0);
`ifdef FIFO_WR_ALMOST_FULL_EN
      exp_af = (i >= 14);
`else
      exp_af = 1'b0;
`endif
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL fill_ready cyc=%0d got=%b want=01", i, ready); end
      checks++; if (wr_addr !== 4'(i)) begin failures++; $display("FAIL fill_addr cyc=%0d got=%0d want=%0d", i, wr_addr, i); end
      checks++; if (wr_full !== 1'b0) begin failures++; $display("FAIL fill_early_full cyc=%0d got=%b want=0", i, wr_full); end
      checks++; if (wr_af !== exp_af) begin failures++; $display("FAIL fill_af cyc=%0d got=%b want=%b", i, wr_af, exp_af); end
      checks++;
      if (wr_en !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL fill_write cyc=%0d wr_en=%b queued=%0d", i, wr_en, sb.size());
      end else begin
        got = {wr_addr, wr_data}; exp_w = sb.pop_front();
        if (got !== exp_w) begin failures++; $display("FAIL fill_sb cyc=%0d got=%h want=%h", i, got, exp_w); end
      end
      advance();
    end
    apply(1'b1, 2'b01, 8'h50, 8'hEE, '0);
    checks++; if (wr_full !== 1'b1) begin failures++; $display("FAIL full_set got=%b want=1", wr_full); end
    checks++; if (wr_ptr !== 5'b11000) begin failures++; $display("FAIL full_wr_ptr got=%b want=11000", wr_ptr); end
    checks++; if (ready !== 2'b00) begin failures++; $display("FAIL full_ready got=%b want=00", ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL full_wr_en got=%b want=0", wr_en); end
    checks++; if (wr_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", wr_ovf); end
    advance();
    apply(1'b1, 2'b01, 8'h51, 8'hEE, '0);
    checks++; if (wr_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", wr_ovf); end
    advance();
  endtask

  task automatic test_release();
    apply(1'b1, 2'b01, 8'h77, 8'hEE, 5'b00001);
    checks++; if (wr_full !== 1'b1 || ready !== 2'b00) begin
      failures++; $display("FAIL release_delay full=%b ready=%b want full=1 ready=00", wr_full, ready);
    end
    advance();
    apply(1'b1, 2'b01, 8'h78, 8'hEE, 5'b00001);
    checks++; if (wr_full !== 1'b0) begin failures++; $display("FAIL release_full got=%b want=0", wr_full); end
    checks++; if (wr_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", wr_ovf); end
    checks++; if (ready !== 2'b01 || wr_addr !== 4'd0) begin
      failures++; $display("FAIL release_write ready=%b addr=%0d want ready=01 addr=0", ready, wr_addr);
    end
    checks++;
    if (wr_en !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL release_sb_write wr_en=%b queued=%0d", wr_en, sb.size());
    end else begin
      got = {wr_addr, wr_data}; exp_w = sb.pop_front();
      if (got !== exp_w) begin failures++; $display("FAIL release_sb got=%h want=%h", got, exp_w); end
    end
    advance();
    apply(1'b1, 2'b00, '0, '0, 5'b00001);
    checks++; if (wr_ptr !== 5'b11001) begin failures++; $display("FAIL release_wbin17 got=%b want=11001", wr_ptr); end
    checks++; if (wr_full !== m_full) begin failures++; $display("FAIL refill_full got=%b want=%b", wr_full, m_full); end
    advance();
  endtask

  task automatic test_wrap();
    logic [AW:0] prev, r;
    logic [DW-1:0] b;
    test_reset();
    prev = wr_ptr;
    for (int i = 0; i < 40; i++) begin
      r = 5'(i) - 5'd2;
      b = 8'hC0 ^ 8'(i);
      apply(1'b1, 2'b10, 8'h00, b, to_gray(r));
      checks++; if (ready !== 2'b10 || wr_full !== 1'b0) begin
        failures++; $display("FAIL wrap_ready cyc=%0d ready=%b full=%b want 10/0", i, ready, wr_full);
      end
      checks++; if (wr_addr !== 4'(i)) begin failures++; $display("FAIL wrap_addr cyc=%0d got=%0d want=%0d", i, wr_addr, i % 16); end
      checks++; if (wr_af !== m_af) begin failures++; $display("FAIL wrap_af cyc=%0d got=%b want=%b", i, wr_af, m_af); end
      checks++;
      if (wr_en !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL wrap_write cyc=%0d wr_en=%b queued=%0d", i, wr_en, sb.size());
      end else begin
        got = {wr_addr, wr_data}; exp_w = sb.pop_front();
        if (got !== exp_w) begin failures++; $display("FAIL wrap_sb cyc=%0d got=%h want=%h", i, got, exp_w); end
      end
      advance();
      checks++; if ($countones(wr_ptr ^ prev) != 1) begin
        failures++; $display("FAIL wrap_gray_step cyc=%0d prev=%b now=%b", i, prev, wr_ptr);
      end
      if (i == 31) begin
        checks++; if (wr_ptr !== 5'b00000) begin failures++; $display("FAIL wrap_to_zero got=%b want=00000", wr_ptr); end
      end
      prev = wr_ptr;
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    rstn = 1'b0; valid = 2'b00; d0 = '0; d1 = '0; rptr = '0;
    m_wbin = '0; m_full = 1'b0; m_last = 1'b1; m_ovf = 1'b0; m_af = 1'b0; m_gnt = 2'b00;
    @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_fill_and_ovf();
    test_release();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the asynchronous FIFO. It shares the single FIFO write port between two requesters with round-robin arbitration. It owns the write pointer in binary and Gray form and drives the memory write enable, address and data. It computes full (and optionally almost-full) against the read pointer already synchronised into the write domain (`wrq2_rptr`). It lives entirely in the write clock domain, alongside the r2w synchroniser that feeds it.

## Interface
- `ADDR_SIZE`, 4, FIFO address width; depth = 2^ADDR_SIZE
- `DATA_SIZE`, 8, data word width
- `AF_MARGIN`, 2, almost-full when free slots <= AF_MARGIN (1..2^ADDR_SIZE-1)

Ports:
- `wr_clk`  in  1  write clock, all logic on rising edge
- `wr_rstn`  in  1  reset, **synchronous, active-low**
- `req_valid`  in  2  per-requester write request
- `req_data0`, `req_data1`  in  DATA_SIZE  requester data
- `req_ready`  out  2  per-requester accept; transfer on `valid & ready`
- `wrq2_rptr`  in  ADDR_SIZE+1  Gray read pointer, already synchronised to `wr_clk`
- `wr_en`  out  1  memory write strobe
- `wr_addr`  out  ADDR_SIZE  memory write address
- `wr_data`  out  DATA_SIZE  memory write data
- `wr_ptr`  out  ADDR_SIZE+1  Gray write pointer, registered, to the w2r synchroniser
- `wr_full`  out  1  FIFO full, registered
- `wr_almost_full`  out  1  almost-full, registered (macro only)
- `wr_ovf`  out  1  sticky: a request was presented while full

## Operation
- State: `wbin` (ADDR_SIZE+1 binary), `wr_ptr` (Gray), `wr_full`, `last_gnt` (1 bit), `wr_ovf`.
- Reset values: `wbin`=0, `wr_ptr`=0, `wr_full`=0, `wr_almost_full`=0, `wr_ovf`=0, `last_gnt`=1 (requester 0 wins first contention).
- Arbiter (combinational from registered state):
  - `req_ready`=0 when `wr_full`=1 or `wr_rstn`=0.
  - With one requester valid, that requester gets ready.
  - With both valid, the requester != `last_gnt` gets ready.
  - At most one bit of `req_ready` is set.
- `wr_en` = |(`req_valid & req_ready`); `wr_addr` = `wbin[ADDR_SIZE-1:0]`; `wr_data` = granted requester's data (0 when idle).
- On transfer: `wbin_next` = `wbin`+1 (wraps mod 2^(ADDR_SIZE+1)) and `last_gnt` = granted index. Otherwise `wbin_next` = `wbin`.
- `wr_ptr` <= `wbin_next ^ (wbin_next>>1)`.
- `wr_full` <= (Gray(`wbin_next`) == {~`wrq2_rptr`[ADDR_SIZE:ADDR_SIZE-1], `wrq2_rptr`[ADDR_SIZE-2:0]}).
- `wr_ovf` <= `wr_ovf` | (|`req_valid` & `wr_full`). It is cleared only by reset.
- A non-granted valid request holds its data stable. Dropping valid without ready is legal.

## Timing
- Write on cycle N: `wr_en`/`wr_addr`/`wr_data` valid in N. `wbin`, `wr_ptr` and `wr_full` update at the N→N+1 edge.
- Full assertion: the write that fills the last slot sets `wr_full` on the next edge, so there is never a write while full.
- Full release: `wr_full` clears one `wr_clk` after `wrq2_rptr` advances, giving a pessimistic 1-cycle delay.
- Pointer wrap from 2^(ADDR_SIZE+1)-1 to 0 is seamless. Gray changes exactly one bit per write.
- Reset mid-operation: at the first edge with `wr_rstn`=0, all state takes reset values. `req_ready`=0 during that cycle, so no write occurs.
- Throughput: one write per cycle while not full. Two requesters both continuously valid alternate 0,1,0,1.

## Configuration
- `FIFO_WR_ALMOST_FULL_EN` defined:
  - `used` = `wbin_next` − Gray2Bin(`wrq2_rptr`), modulo 2^(ADDR_SIZE+1).
  - `wr_almost_full` <= (2^ADDR_SIZE − `used`) <= `AF_MARGIN`.
  - The flag is registered and updates on the same edge as `wr_full`.
- Not defined: the port is still present, tied to 0, and there is no gray-to-binary logic.

## Test plan
(ADDR_SIZE=4, AF_MARGIN=2)
- Reset: drive `wr_rstn`=0 for 2 cycles with both valid → `req_ready`=00, `wr_en`=0, `wr_ptr`=0, `wr_full`=0, `wr_ovf`=0.
- Fill: only requester 0 valid, `wrq2_rptr`=0. Expect 16 writes at addr 0..15. `wr_full`=1 on the cycle after the 16th write, `wr_ptr`=5'b11000, then `req_ready`=00. `wr_almost_full` rises after the 14th write (macro on).
- Contention: both valid from reset for 6 cycles → grants 0,1,0,1,0,1 and `wr_data` alternates between `req_data0`/`req_data1`.
- Release: from full, set `wrq2_rptr`=5'b00001 → `wr_full`=0 one cycle later. The next write goes to addr 0 with `wbin`=17.
- Overflow flag: valid held while full → `wr_ovf`=1 the next cycle and stays 1 after full clears, until reset.
- Wrap: run 40 write/release cycles → `wr_ptr` changes exactly one bit per write, and `wbin` wraps 31→0 with no spurious full.
